sccb_write_master: RTL and testbench

SCCB_WRITE_MASTER -- requirements
Module: sccb_write_master

---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_shift_reg.sv | 27 ++
 rtl/sccb_write_master.sv | 151 +++++++++++++++
 tb/tb_sccb_write_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state type, frame geometry and the default camera write address.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_DONE
  } sccbState_e;

  localparam int SCCB_BITS        = 27;
  localparam int SCCB_START_TICKS = 2;
  localparam int SCCB_STOP_TICKS  = 3;
  localparam logic [7:0] SCCB_DEV_ADDR = 8'h42;

  // Every ninth bit of the frame (indices 8, 17, 26) is the slave's ACK slot.
  function automatic logic isAckBit(input logic [4:0] bitIdx);
    return (bitIdx == 5'd8) || (bitIdx == 5'd17) || (bitIdx == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_shift_reg.sv
// 27-bit frame shifter: parallel load, shift left, MSB presented as the next SIOD bit.
module sccb_shift_reg
  import sccb_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iLoad,
  input  logic                 iShift,
  input  logic [SCCB_BITS-1:0] iLoadData,
  output logic                 oMsb
);

  logic [SCCB_BITS-1:0] shiftReg;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      shiftReg <= '0;
    end else if (iLoad) begin
      shiftReg <= iLoadData;
    end else if (iShift) begin
      shiftReg <= {shiftReg[SCCB_BITS-2:0], 1'b0};
    end
  end

  assign oMsb = shiftReg[SCCB_BITS-1];

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master (device addr, register addr, register data) paced by iEnClk ticks.
// Optional ACK checking is enabled by defining SCCB_ACK_CHECK_EN.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = SCCB_DEV_ADDR
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEnClk,
  input  logic       iStart,
  input  logic [7:0] iRegAddr,
  input  logic [7:0] iRegData,
  input  logic       iSioD,
  output logic       oSioC,
  output logic       oSioD,
  output logic       oSioDOe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oNack
);

  sccbState_e  state;
  logic [4:0]  bitCnt;
  logic [1:0]  phase;
  logic        frameMsb;
  logic        acceptStart;
  logic        shiftEn;

  assign acceptStart = (state == ST_IDLE) && iStart;
  assign shiftEn     = (state == ST_BIT) && iEnClk && (phase == 2'd3);

  sccb_shift_reg uShiftReg (
    .iClk      (iClk),
    .iRst      (iRst),
    .iLoad     (acceptStart),
    .iShift    (shiftEn),
    .iLoadData ({DEV_ADDR, 1'b1, iRegAddr, 1'b1, iRegData, 1'b1}),
    .oMsb      (frameMsb)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= ST_IDLE;
      oSioC   <= 1'b1;
      oSioD   <= 1'b1;
      oSioDOe <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      bitCnt  <= '0;
      phase   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state  <= ST_START;
            oBusy  <= 1'b1;
            bitCnt <= '0;
            phase  <= '0;
          end
        end
        ST_START: if (iEnClk) begin
          if (phase == 2'(SCCB_START_TICKS - 1)) begin
            oSioC <= 1'b0;
            phase <= '0;
            state <= ST_BIT;
          end else begin
            oSioD   <= 1'b0;
            oSioDOe <= 1'b1;
            oSioC   <= 1'b1;
            phase   <= phase + 2'd1;
          end
        end
        // Quarter-bit phases: q0 set data with SIOC low, q1/q2 SIOC high, q3 SIOC low.
        ST_BIT: if (iEnClk) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: begin
              oSioC   <= 1'b0;
              oSioD   <= frameMsb;
              oSioDOe <= !isAckBit(bitCnt);
            end
            2'd1, 2'd2: oSioC <= 1'b1;
            default: begin
              oSioC <= 1'b0;
              if (bitCnt == 5'(SCCB_BITS - 1)) begin
                bitCnt <= '0;
                state  <= ST_STOP;
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
            end
          endcase
        end
        ST_STOP: if (iEnClk) begin
          phase <= phase + 2'd1;
          if (phase == 2'd0) begin
            oSioD   <= 1'b0;
            oSioDOe <= 1'b1;
            oSioC   <= 1'b0;
          end else if (phase != 2'(SCCB_STOP_TICKS - 1)) begin
            oSioC <= 1'b1;
          end else begin
            oSioD <= 1'b1;
            phase <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          oDone   <= 1'b1;
          oBusy   <= 1'b0;
          oSioDOe <= 1'b0;
          oSioC   <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  logic nackAcc;
  logic nackReg;
  logic ackSample;

  assign ackSample = (state == ST_BIT) && iEnClk && (phase == 2'd2) && isAckBit(bitCnt);

  // Sticky per-frame accumulator, published to oNack only when the frame finishes.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      nackAcc <= 1'b0;
      nackReg <= 1'b0;
    end else if (acceptStart) begin
      nackAcc <= 1'b0;
      nackReg <= 1'b0;
    end else if (ackSample) begin
      nackAcc <= nackAcc | iSioD;
    end else if (state == ST_DONE) begin
      nackReg <= nackAcc;
    end
  end

  assign oNack = nackReg;
`else
  logic unusedSioD;
  assign unusedSioD = iSioD;
  assign oNack      = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_write_master.sv
// Randomized self-checking bench for sccb_write_master; bus activity is decoded from SIOC/SIOD edges.
module tb_sccb_write_master;

  localparam logic [7:0] DEV = 8'h42;
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic iEnClk = 1'b0;
  logic iStart = 1'b0;
  logic [7:0] iRegAddr = '0;
  logic [7:0] iRegData = '0;
  logic iSioD = 1'b0;
  logic oSioC, oSioD, oSioDOe, oBusy, oDone, oNack;

  int checks = 0;
  int errors = 0;

  logic tickEnable = 1'b1;
  logic [1:0] divCnt = '0;

  logic [26:0] obsData, obsOe;
  int riseCnt, startCnt, stopCnt, doneCnt, doneAt, holdViol, busyLowEarly;
  logic nackAtDone, busyAtDone, rstC, rstOe, rstBusy;

  sccb_write_master #(.DEV_ADDR(DEV)) dut (
    .iClk(iClk), .iRst(iRst), .iEnClk(iEnClk), .iStart(iStart),
    .iRegAddr(iRegAddr), .iRegData(iRegData), .iSioD(iSioD),
    .oSioC(oSioC), .oSioD(oSioD), .oSioDOe(oSioDOe),
    .oBusy(oBusy), .oDone(oDone), .oNack(oNack)
  );

  always #5 iClk = ~iClk;

  // Upstream clock-enable: one tick every fourth clock, updated away from the active edge.
  always @(negedge iClk) begin
    divCnt = divCnt + 2'd1;
    iEnClk = tickEnable && (divCnt == 2'd0);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference frame: each byte MSB first followed by a released ACK slot.
  task automatic expStream(input logic [7:0] a, input logic [7:0] d,
                           output logic [26:0] ed, output logic [26:0] eo);
    logic [7:0] bytes [3];
    bytes[0] = DEV; bytes[1] = a; bytes[2] = d;
    ed = '0; eo = '0;
    for (int k = 0; k < 27; k++) begin
      if (k % 9 != 8) begin
        ed[26-k] = bytes[k/9][7 - (k % 9)];
        eo[26-k] = 1'b1;
      end
    end
  endtask

  task automatic runWatch(input logic [7:0] addr, input logic [7:0] data, input logic [2:0] mask,
                          input bit issueStart, input int restartAt, input int pauseAt,
                          input int resetAt, input bit stopAtDone, input int limit);
    int cycles;
    logic prevC, prevLine, c, line;
    logic [2:0] snap;
    obsData = '0; obsOe = '0;
    riseCnt = 0; startCnt = 0; stopCnt = 0; doneCnt = 0; doneAt = -1;
    holdViol = 0; busyLowEarly = 0; nackAtDone = 1'bx; busyAtDone = 1'bx;
    snap = '0;
    if (issueStart) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge iClk); #1;
        if (iEnClk) break;
      end
      iRegAddr = addr; iRegData = data; iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
    end
    cycles = 0;
    prevC = oSioC;
    prevLine = oSioDOe ? oSioD : 1'b1;
    while (cycles < limit) begin
      @(posedge iClk); #1;
      cycles++;
      iStart = (cycles == restartAt);
      if (cycles == restartAt) begin
        iRegAddr = ~addr; iRegData = ~data;
      end
      if (cycles == pauseAt) begin
        tickEnable = 1'b0;
        snap = {oSioC, oSioD, oSioDOe};
      end else if (pauseAt > 0 && cycles > pauseAt && cycles <= pauseAt + 50) begin
        if ({oSioC, oSioD, oSioDOe} !== snap) holdViol++;
        if (cycles == pauseAt + 50) tickEnable = 1'b1;
      end
      if (cycles == resetAt) begin
        iRst = 1'b1; #1;
        rstC = oSioC; rstOe = oSioDOe; rstBusy = oBusy;
      end
      if (resetAt > 0 && cycles == resetAt + 2) iRst = 1'b0;
      c = oSioC;
      line = oSioDOe ? oSioD : 1'b1;
      if (prevC === 1'b0 && c === 1'b1) begin
        if (riseCnt < 27) begin
          obsData[26-riseCnt] = oSioD;
          obsOe[26-riseCnt]   = oSioDOe;
        end
        riseCnt++;
        if (riseCnt == 9)  iSioD = mask[0];
        if (riseCnt == 18) iSioD = mask[1];
        if (riseCnt == 27) iSioD = mask[2];
      end
      if (prevC === 1'b1 && c === 1'b0) iSioD = 1'b0;
      if (prevC === 1'b1 && c === 1'b1 && prevLine === 1'b1 && line === 1'b0) startCnt++;
      if (prevC === 1'b1 && c === 1'b1 && prevLine === 1'b0 && line === 1'b1) stopCnt++;
      prevC = c;
      prevLine = line;
      if (doneAt < 0 && oDone !== 1'b1 && oBusy !== 1'b1) busyLowEarly++;
      if (oDone === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = cycles; nackAtDone = oNack; busyAtDone = oBusy;
        end
        if (stopAtDone) break;
      end
    end
    iSioD = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0; iSioD = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checks++; if (oSioC !== 1'b1) begin errors++; $display("[TB] FAIL reset_sioc: got %b expected 1", oSioC); end
    checks++; if (oSioD !== 1'b1) begin errors++; $display("[TB] FAIL reset_siod: got %b expected 1", oSioD); end
    checks++; if (oSioDOe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", oSioDOe); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", oBusy); end
    checks++; if (oDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", oDone); end
    checks++; if (oNack !== 1'b0) begin errors++; $display("[TB] FAIL reset_nack: got %b expected 0", oNack); end
    @(negedge iClk);
    iRst = 1'b0;
    repeat (3) @(posedge iClk);
  endtask

  task automatic test_write_frame();
    logic [7:0] a, d;
    logic [2:0] m;
    logic [26:0] ed, eo;
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 8'h12 : 8'($urandom);
      d = (t == 0) ? 8'h80 : 8'($urandom);
      m = (t == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      expStream(a, d, ed, eo);
      runWatch(a, d, m, 1'b1, -1, -1, -1, 1'b0, 470);
      checks++; if ((obsData & eo) !== ed) begin errors++; $display("[TB] FAIL frame_data: got %h expected %h", obsData & eo, ed); end
      checks++; if (obsOe !== eo) begin errors++; $display("[TB] FAIL frame_oe: got %h expected %h", obsOe, eo); end
      checks++; if (doneAt != 113 * 4 + 1) begin errors++; $display("[TB] FAIL frame_latency: got %0d expected %0d", doneAt, 113 * 4 + 1); end
      checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL frame_done_count: got %0d expected 1", doneCnt); end
      checks++; if (riseCnt != 28) begin errors++; $display("[TB] FAIL frame_sioc_rises: got %0d expected 28", riseCnt); end
      checks++; if (startCnt != 1 || stopCnt != 1) begin errors++; $display("[TB] FAIL frame_start_stop: got %0d/%0d expected 1/1", startCnt, stopCnt); end
      checks++; if (busyLowEarly != 0) begin errors++; $display("[TB] FAIL frame_busy_held: got %0d low cycles expected 0", busyLowEarly); end
      checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL frame_busy_at_done: got %b expected 0", busyAtDone); end
      checks++; if (nackAtDone !== (ACK_EN & (|m))) begin errors++; $display("[TB] FAIL frame_nack: got %b expected %b", nackAtDone, ACK_EN & (|m)); end
    end
  endtask

  task automatic test_ignore_restart();
    logic [7:0] a, d;
    logic [26:0] ed, eo;
    a = 8'($urandom); d = 8'($urandom);
    expStream(a, d, ed, eo);
    runWatch(a, d, 3'b000, 1'b1, 200, -1, -1, 1'b0, 470);
    checks++; if ((obsData & eo) !== ed) begin errors++; $display("[TB] FAIL restart_data: got %h expected %h", obsData & eo, ed); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL restart_done_count: got %0d expected 1", doneCnt); end
    checks++; if (doneAt != 453) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 453", doneAt); end
  endtask

  task automatic test_pause();
    logic [7:0] a, d;
    logic [26:0] ed, eo;
    a = 8'($urandom); d = 8'($urandom);
    expStream(a, d, ed, eo);
    runWatch(a, d, 3'b000, 1'b1, -1, 150, -1, 1'b0, 560);
    checks++; if (holdViol != 0) begin errors++; $display("[TB] FAIL pause_hold: got %0d changed cycles expected 0", holdViol); end
    checks++; if ((obsData & eo) !== ed) begin errors++; $display("[TB] FAIL pause_data: got %h expected %h", obsData & eo, ed); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL pause_done_count: got %0d expected 1", doneCnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, d;
    logic [26:0] ed, eo;
    a = 8'($urandom); d = 8'($urandom);
    runWatch(a, d, 3'b000, 1'b1, -1, -1, 208, 1'b0, 300);
    checks++; if (rstC !== 1'b1) begin errors++; $display("[TB] FAIL abort_sioc: got %b expected 1", rstC); end
    checks++; if (rstOe !== 1'b0) begin errors++; $display("[TB] FAIL abort_oe: got %b expected 0", rstOe); end
    checks++; if (rstBusy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", rstBusy); end
    checks++; if (doneCnt != 0) begin errors++; $display("[TB] FAIL abort_done_count: got %0d expected 0", doneCnt); end
    a = 8'($urandom); d = 8'($urandom);
    expStream(a, d, ed, eo);
    runWatch(a, d, 3'b000, 1'b1, -1, -1, -1, 1'b0, 470);
    checks++; if ((obsData & eo) !== ed) begin errors++; $display("[TB] FAIL abort_retry_data: got %h expected %h", obsData & eo, ed); end
    checks++; if (doneAt != 453) begin errors++; $display("[TB] FAIL abort_retry_latency: got %0d expected 453", doneAt); end
  endtask

  task automatic test_nack();
    logic [7:0] a, d;
    a = 8'($urandom); d = 8'($urandom);
    runWatch(a, d, 3'b010, 1'b1, -1, -1, -1, 1'b0, 470);
    checks++; if (nackAtDone !== ACK_EN) begin errors++; $display("[TB] FAIL nack_second_ack: got %b expected %b", nackAtDone, ACK_EN); end
    checks++; if (oNack !== ACK_EN) begin errors++; $display("[TB] FAIL nack_held: got %b expected %b", oNack, ACK_EN); end
    runWatch(a, d, 3'b000, 1'b1, -1, -1, -1, 1'b0, 470);
    checks++; if (nackAtDone !== 1'b0) begin errors++; $display("[TB] FAIL nack_cleared: got %b expected 0", nackAtDone); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, d;
    logic [26:0] ed, eo;
    a = 8'($urandom); d = 8'($urandom);
    runWatch(a, d, 3'b000, 1'b1, -1, -1, -1, 1'b1, 470);
    checks++; if (doneAt != 453 || busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d/%b expected 453/0", doneAt, busyAtDone); end
    a = 8'($urandom); d = 8'($urandom);
    iRegAddr = a; iRegData = d; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_gap: got busy %b expected 1", oBusy); end
    expStream(a, d, ed, eo);
    runWatch(a, d, 3'b000, 1'b0, -1, -1, -1, 1'b0, 470);
    checks++; if ((obsData & eo) !== ed) begin errors++; $display("[TB] FAIL b2b_second_data: got %h expected %h", obsData & eo, ed); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL b2b_second_done: got %0d expected 1", doneCnt); end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_ignore_restart();
    test_pause();
    test_reset_mid();
    test_nack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
